// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze sequencer: beeps on an alarm match, supports snooze,
// dismiss, disarm and auto-stop with a sticky missed flag.
module alarm_sequencer #(
  parameter int BEEP_ON      = 2,
  parameter int BEEP_OFF     = 2,
  parameter int RING_TIMEOUT = 12,
  parameter int SNOOZE_LEN   = 8,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm,
  input  logic       enable,
  input  logic       snooze_btn,
  input  logic       dismiss_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_count,
  output logic       missed
);

  localparam int PER = BEEP_ON + BEEP_OFF;
  localparam int RW  = $clog2(RING_TIMEOUT + 1);
  localparam int SW  = $clog2(SNOOZE_LEN + 1);
  localparam int PW  = $clog2(PER + 1);

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

  state_t        state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic          ring_last;
  logic          snz_last;
  logic          snz_ok;

  assign phase_nxt = (phase == PW'(PER - 1)) ? '0 : phase + 1'b1;
  assign ring_last = (ring_cnt == RW'(RING_TIMEOUT - 1));
  assign snz_last  = (snz_cnt == SW'(SNOOZE_LEN - 1));
  assign snz_ok    = (snooze_count < 2'(MAX_SNOOZE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      snooze_count <= '0;
      missed       <= 1'b0;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      phase        <= '0;
    end else if (!enable) begin
      state        <= IDLE;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      snooze_count <= '0;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      phase        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dismiss_btn) begin
            missed <= 1'b0;
          end else if (alarm) begin
            state        <= RING;
            ringing      <= 1'b1;
            buzzer       <= 1'b1;
            ring_cnt     <= '0;
            phase        <= '0;
            snooze_count <= '0;
          end
        end
        RING: begin
          if (dismiss_btn) begin
            state        <= IDLE;
            ringing      <= 1'b0;
            buzzer       <= 1'b0;
            snooze_count <= '0;
            missed       <= 1'b0;
          end else if (snooze_btn && snz_ok) begin
            state        <= SNOOZE;
            ringing      <= 1'b0;
            snoozing     <= 1'b1;
            buzzer       <= 1'b0;
            snz_cnt      <= '0;
            snooze_count <= snooze_count + 1'b1;
          end else if (ring_last) begin
            state        <= IDLE;
            ringing      <= 1'b0;
            buzzer       <= 1'b0;
            snooze_count <= '0;
            missed       <= 1'b1;
          end else begin
            ring_cnt <= ring_cnt + 1'b1;
            phase    <= phase_nxt;
            buzzer   <= (phase_nxt < PW'(BEEP_ON));
          end
        end
        SNOOZE: begin
          if (dismiss_btn) begin
            state        <= IDLE;
            snoozing     <= 1'b0;
            snooze_count <= '0;
            missed       <= 1'b0;
          end else if (snz_last) begin
            // re-ring restarts both the timeout and the beep pattern
            state    <= RING;
            snoozing <= 1'b0;
            ringing  <= 1'b1;
            buzzer   <= 1'b1;
            ring_cnt <= '0;
            phase    <= '0;
          end else begin
            snz_cnt <= snz_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alarm = 1'b0;
  logic       enable = 1'b1;
  logic       snooze_btn = 1'b0;
  logic       dismiss_btn = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic       missed;

  alarm_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .alarm       (alarm),
    .enable      (enable),
    .snooze_btn  (snooze_btn),
    .dismiss_btn (dismiss_btn),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_count(snooze_count),
    .missed      (missed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // model: mode 0 idle, 1 ring, 2 snooze; t = cycles already spent in mode
  int m_mode = 0;
  int m_t    = 0;
  int m_sc   = 0;
  int m_miss = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_t = 0; m_sc = 0; m_miss = 0;
    end else if (!enable) begin
      m_mode = 0; m_t = 0; m_sc = 0;
    end else if (m_mode == 0) begin
      if (dismiss_btn) m_miss = 0;
      else if (alarm) begin
        m_mode = 1; m_t = 0; m_sc = 0;
      end
    end else if (dismiss_btn) begin
      m_mode = 0; m_sc = 0; m_miss = 0;
    end else if (m_mode == 1) begin
      if (snooze_btn && m_sc < 3) begin
        m_mode = 2; m_t = 0; m_sc++;
      end else if (m_t + 1 == 12) begin
        m_mode = 0; m_sc = 0; m_miss = 1;
      end else m_t++;
    end else begin
      if (m_t + 1 == 8) begin
        m_mode = 1; m_t = 0;
      end else m_t++;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.ringing", int'(ringing), int'(m_mode == 1));
      chk("model.snoozing", int'(snoozing), int'(m_mode == 2));
      chk("model.buzzer", int'(buzzer),
          int'(m_mode == 1 && (m_t % 4) < 2));
      chk("model.snooze_count", int'(snooze_count), m_sc);
      chk("model.missed", int'(missed), m_miss);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_alarm();
    alarm = 1'b1;
    step();
    alarm = 1'b0;
  endtask

  int pat [4];
  int waited;

  initial begin
    pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0;
    step();
    reset = 1'b0;
    chk("rst.buzzer", int'(buzzer), 0);
    chk("rst.ringing", int'(ringing), 0);
    chk("rst.snoozing", int'(snoozing), 0);
    chk("rst.count", int'(snooze_count), 0);
    chk("rst.missed", int'(missed), 0);
    chk_en = 1'b1;

    // unattended alarm times out
    pulse_alarm();
    for (int i = 0; i < 12; i++) begin
      chk("to.ringing", int'(ringing), 1);
      chk("to.buzzer", int'(buzzer), pat[i%4]);
      step();
    end
    chk("to.idle", int'(ringing), 0);
    chk("to.missed", int'(missed), 1);
    chk("to.count", int'(snooze_count), 0);

    // snooze at ring cycle 3
    pulse_alarm();
    step(3);
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    chk("snz.count", int'(snooze_count), 1);
    chk("snz.buzzer", int'(buzzer), 0);
    for (int i = 0; i < 8; i++) begin
      chk("snz.snoozing", int'(snoozing), 1);
      step();
    end
    chk("snz.rering", int'(ringing), 1);
    chk("snz.buzz_restart", int'(buzzer), 1);
    chk("snz.count_kept", int'(snooze_count), 1);
    dismiss_btn = 1'b1;
    step();
    dismiss_btn = 1'b0;
    chk("dis.ringing", int'(ringing), 0);
    chk("dis.missed", int'(missed), 0);

    // four snooze attempts
    pulse_alarm();
    for (int k = 0; k < 4; k++) begin
      step();
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      if (k < 3) begin
        chk("max.snoozing", int'(snoozing), 1);
        chk("max.count", int'(snooze_count), k + 1);
        step(8);
        chk("max.rering", int'(ringing), 1);
      end else begin
        chk("max.ignored", int'(ringing), 1);
        chk("max.count3", int'(snooze_count), 3);
      end
    end
    waited = 0;
    while (ringing && waited < 20) begin
      step();
      waited++;
    end
    chk("max.timeout_bound", int'(waited < 20), 1);
    chk("max.rem_cycles", waited, 10);
    chk("max.missed", int'(missed), 1);
    chk("max.count0", int'(snooze_count), 0);

    // dismiss and snooze together
    pulse_alarm();
    step();
    dismiss_btn = 1'b1;
    snooze_btn  = 1'b1;
    step();
    dismiss_btn = 1'b0;
    snooze_btn  = 1'b0;
    chk("both.ringing", int'(ringing), 0);
    chk("both.snoozing", int'(snoozing), 0);
    chk("both.count", int'(snooze_count), 0);
    chk("both.missed", int'(missed), 0);

    // disarm during snooze, then alarm while disarmed
    pulse_alarm();
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    chk("en.snoozing", int'(snoozing), 1);
    enable = 1'b0;
    step();
    chk("en.idle", int'(snoozing), 0);
    chk("en.count", int'(snooze_count), 0);
    alarm = 1'b1;
    step();
    alarm = 1'b0;
    step();
    chk("en.no_ring", int'(ringing), 0);
    enable = 1'b1;

    // reset mid-ring
    pulse_alarm();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr.buzzer", int'(buzzer), 0);
    chk("rr.ringing", int'(ringing), 0);
    chk("rr.count", int'(snooze_count), 0);
    pulse_alarm();
    chk("rr.ring", int'(ringing), 1);
    chk("rr.buzz", int'(buzzer), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      alarm       = ($urandom_range(0, 7) == 0);
      enable      = ($urandom_range(0, 39) != 0);
      snooze_btn  = ($urandom_range(0, 9) == 0);
      dismiss_btn = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    alarm = 1'b0;
    snooze_btn = 1'b0;
    dismiss_btn = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter BEEP_ON, default 2, buzzer-high cycles per beep period.
REQ-002 SHALL have parameter BEEP_OFF, default 2, buzzer-low cycles per beep period.
REQ-003 SHALL have parameter RING_TIMEOUT, default 12, maximum cycles in RING before auto-stop.
REQ-004 SHALL have parameter SNOOZE_LEN, default 8, cycles spent in SNOOZE before re-ringing.
REQ-005 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (1..3).
REQ-006 SHALL have port clk  input  1  single clock; one cycle is one clock-second.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port alarm  input  1  one-cycle match pulse from the upstream clock/alarm block.
REQ-009 SHALL have port enable  input  1  alarm arm switch; low disarms.
REQ-010 SHALL have port snooze_btn  input  1  snooze request, level-sampled, already debounced.
REQ-011 SHALL have port dismiss_btn  input  1  dismiss request, level-sampled, already debounced.
REQ-012 SHALL have port buzzer  output  1  registered beep pattern.
REQ-013 SHALL have port ringing  output  1  high while in RING.
REQ-014 SHALL have port snoozing  output  1  high while in SNOOZE.
REQ-015 SHALL have port snooze_count  output  2  snoozes used in current alarm event.
REQ-016 SHALL have port missed  output  1  sticky flag: last ring ended by timeout.

Function
REQ-017 SHALL implement states IDLE, RING, SNOOZE; all outputs registered.
REQ-018 SHALL evaluate transitions per cycle in priority order: reset > enable low > dismiss_btn > snooze_btn > timeout/expiry.
REQ-019 SHALL, in IDLE with alarm=1 and enable=1 at edge N, be in RING with ringing=1, buzzer=1 from edge N (one-cycle latency); ring counter and beep phase counter start at 0 and snooze_count is cleared.
REQ-020 SHALL ignore alarm in IDLE when enable=0, and ignore alarm entirely in RING and SNOOZE.
REQ-021 SHALL drive buzzer in RING high for BEEP_ON cycles then low for BEEP_OFF cycles, repeating from the first RING cycle (defaults: 1,1,0,0,1,1,0,0,...).
REQ-022 SHALL, in RING with snooze_btn=1 and snooze_count<MAX_SNOOZE, enter SNOOZE next cycle, increment snooze_count, load snooze timer, drive buzzer=0.
REQ-023 SHALL ignore snooze_btn in RING when snooze_count==MAX_SNOOZE (keep ringing, pattern and ring counter undisturbed).
REQ-024 SHALL, after SNOOZE_LEN cycles in SNOOZE, re-enter RING with ring counter and beep phase restarted at 0; snooze_count retained.
REQ-025 SHALL ignore snooze_btn while in SNOOZE (timer not reloaded).
REQ-026 SHALL, on dismiss_btn=1 in RING or SNOOZE, go to IDLE next cycle, clear snooze_count, clear missed.
REQ-027 SHALL, on dismiss_btn=1 in IDLE, clear missed.
REQ-028 SHALL leave RING to IDLE after exactly RING_TIMEOUT RING cycles with no button, set missed=1, clear snooze_count.
REQ-029 SHALL, when enable=0 in any state, go to IDLE next cycle, clear snooze_count, buzzer=0; missed unchanged.
REQ-030 SHALL, when dismiss_btn and snooze_btn are both high, treat it as dismiss.
REQ-031 SHALL size internal counters to hold RING_TIMEOUT, SNOOZE_LEN, BEEP_ON+BEEP_OFF without overflow; no counter wraps within a state.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, enter IDLE with buzzer=0, ringing=0, snoozing=0, snooze_count=0, missed=0, all counters 0, regardless of state or other inputs.
REQ-033 SHALL, with reset asserted mid-RING or mid-SNOOZE, abort without any further buzzer pulse.

Verification
REQ-034 SHALL check: alarm pulse, enable=1, no buttons -> ringing 12 cycles, buzzer 1,1,0,0 x3, then IDLE with missed=1.
REQ-035 SHALL check: snooze at RING cycle 3 -> snoozing=1 for 8 cycles, snooze_count=1, then ringing=1 with buzzer restarting at 1.
REQ-036 SHALL check: four snoozes attempted -> count stops at 3, fourth snooze_btn ignored, ring continues to timeout, missed=1, snooze_count=0.
REQ-037 SHALL check: dismiss and snooze together in RING -> IDLE next cycle, snooze_count=0, missed=0.
REQ-038 SHALL check: enable=0 during SNOOZE -> IDLE next cycle; alarm pulse with enable=0 -> stays IDLE.
REQ-039 SHALL check: reset during RING -> all outputs 0 next cycle; later alarm pulse rings normally.
